// File: rtl/message_check_if.sv
// rtl/message_check_if.sv - byte stream and match/error status bundle for message_check
// The o_error_count member exists only when MESSAGE_CHECK_ERRCNT_EN is defined.
interface message_check_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_match;
    logic       o_error;
    logic [3:0] o_index;
    logic [7:0] o_match_count;
`ifdef MESSAGE_CHECK_ERRCNT_EN
    logic [7:0] o_error_count;
`endif

    modport master (
        output i_valid, i_data,
        input  o_match, o_error, o_index, o_match_count
`ifdef MESSAGE_CHECK_ERRCNT_EN
        , input o_error_count
`endif
    );

    modport slave (
        input  i_valid, i_data,
        output o_match, o_error, o_index, o_match_count
`ifdef MESSAGE_CHECK_ERRCNT_EN
        , output o_error_count
`endif
    );
endinterface

// File: rtl/message_check.sv
// rtl/message_check.sv - detects the 14-byte message "Hello, world!\0" in a byte stream
// Optional saturating error counter is enabled by MESSAGE_CHECK_ERRCNT_EN.
module message_check #(
    parameter int unsigned TIMEOUT = 1000
) (
    input logic           i_clk,
    input logic           i_reset,
    message_check_if.slave bus
);
    typedef enum logic {HUNT, MATCH} state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    localparam logic [7:0]  CHAR_H    = 8'h48;
    localparam logic [3:0]  LAST_IDX  = 4'd13;

    state_t      state_q, state_d;
    logic [3:0]  index_q, index_d;
    logic [15:0] idle_q, idle_d;
    logic        match_q, match_d;
    logic        error_q, error_d;
    logic [7:0]  match_count_q, match_count_d;
    logic [15:0] idle_inc;
`ifdef MESSAGE_CHECK_ERRCNT_EN
    logic [7:0]  error_count_q, error_count_d;
`endif

    function automatic logic [7:0] expected_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    expected_byte = 8'h48; // H
            4'd1:    expected_byte = 8'h65; // e
            4'd2:    expected_byte = 8'h6c; // l
            4'd3:    expected_byte = 8'h6c; // l
            4'd4:    expected_byte = 8'h6f; // o
            4'd5:    expected_byte = 8'h2c; // ,
            4'd6:    expected_byte = 8'h20; // space
            4'd7:    expected_byte = 8'h77; // w
            4'd8:    expected_byte = 8'h6f; // o
            4'd9:    expected_byte = 8'h72; // r
            4'd10:   expected_byte = 8'h6c; // l
            4'd11:   expected_byte = 8'h64; // d
            4'd12:   expected_byte = 8'h21; // !
            default: expected_byte = 8'h00;
        endcase
    endfunction

    assign idle_inc = (idle_q == 16'hffff) ? idle_q : idle_q + 16'd1;

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        idle_d        = idle_q;
        match_d       = 1'b0;
        error_d       = 1'b0;
        match_count_d = match_count_q;
        case (state_q)
            HUNT: begin
                if (bus.i_valid && bus.i_data == CHAR_H) begin
                    state_d = MATCH;
                    index_d = 4'd1;
                    idle_d  = '0;
                end
            end
            default: begin
                if (bus.i_valid) begin
                    idle_d = '0;
                    if (bus.i_data == expected_byte(index_q)) begin
                        if (index_q == LAST_IDX) begin
                            match_d = 1'b1;
                            state_d = HUNT;
                            index_d = '0;
                            if (match_count_q != 8'hff)
                                match_count_d = match_count_q + 8'd1;
                        end else begin
                            index_d = index_q + 4'd1;
                        end
                    end else begin
                        // A stray "H" may itself start a fresh message.
                        error_d = 1'b1;
                        if (bus.i_data == CHAR_H) begin
                            index_d = 4'd1;
                        end else begin
                            state_d = HUNT;
                            index_d = '0;
                        end
                    end
                end else begin
                    idle_d = idle_inc;
                    if (TIMEOUT_W != 16'd0 && idle_inc >= TIMEOUT_W) begin
                        error_d = 1'b1;
                        state_d = HUNT;
                        index_d = '0;
                    end
                end
            end
        endcase
`ifdef MESSAGE_CHECK_ERRCNT_EN
        error_count_d = error_count_q;
        if (error_d && error_count_q != 8'hff)
            error_count_d = error_count_q + 8'd1;
`endif
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= HUNT;
            index_q       <= '0;
            idle_q        <= '0;
            match_q       <= 1'b0;
            error_q       <= 1'b0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            idle_q        <= idle_d;
            match_q       <= match_d;
            error_q       <= error_d;
            match_count_q <= match_count_d;
        end
    end

`ifdef MESSAGE_CHECK_ERRCNT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            error_count_q <= '0;
        else
            error_count_q <= error_count_d;
    end
    assign bus.o_error_count = error_count_q;
`endif

    assign bus.o_match       = match_q;
    assign bus.o_error       = error_q;
    assign bus.o_index       = index_q;
    assign bus.o_match_count = match_count_q;
endmodule

// File: tb/tb_message_check.sv
// tb/tb_message_check.sv - scoreboard bench for message_check with a reference model
module tb_message_check;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    message_check_if bus ();
    message_check #(.TIMEOUT(TO)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    typedef struct {
        logic       m;
        logic       e;
        logic [3:0] idx;
        logic [7:0] mc;
        logic [7:0] ec;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    logic [7:0] msg [0:13] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h2c, 8'h20,
                               8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h00};

    // Model: pos is how many message bytes have been matched, 0 means hunting.
    int pos = 0, idle = 0, mc = 0, ec = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        pos = 0; idle = 0; mc = 0; ec = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        exp_t e;
        e.m = 1'b0;
        e.e = 1'b0;
        bus.i_valid = v;
        bus.i_data  = d;
        if (v) begin
            idle = 0;
            if (pos == 0) begin
                if (d == 8'h48) pos = 1;
            end else if (d == msg[pos]) begin
                if (pos == 13) begin
                    e.m = 1'b1;
                    pos = 0;
                    if (mc < 255) mc++;
                end else begin
                    pos++;
                end
            end else begin
                e.e = 1'b1;
                pos = (d == 8'h48) ? 1 : 0;
            end
        end else if (pos != 0) begin
            if (idle < 65535) idle++;
            if (TO > 0 && idle >= TO) begin
                e.e = 1'b1;
                pos = 0;
            end
        end
        if (e.e && ec < 255) ec++;
        e.idx = 4'(pos);
        e.mc  = 8'(mc);
        e.ec  = 8'(ec);
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("o_match", 16'(bus.o_match), 16'(e.m));
            chk("o_error", 16'(bus.o_error), 16'(e.e));
            chk("o_index", 16'(bus.o_index), 16'(e.idx));
            chk("o_match_count", 16'(bus.o_match_count), 16'(e.mc));
`ifdef MESSAGE_CHECK_ERRCNT_EN
            chk("o_error_count", 16'(bus.o_error_count), 16'(e.ec));
`endif
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        #1;
        chk("reset o_index", 16'(bus.o_index), 16'd0);
        chk("reset o_match", 16'(bus.o_match), 16'd0);
        chk("reset o_error", 16'(bus.o_error), 16'd0);
        chk("reset o_match_count", 16'(bus.o_match_count), 16'd0);
`ifdef MESSAGE_CHECK_ERRCNT_EN
        chk("reset o_error_count", 16'(bus.o_error_count), 16'd0);
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, 8'(s[i]));
    endtask

    task automatic send_msg();
        for (int i = 0; i < 14; i++) step(1'b1, msg[i]);
    endtask

    task automatic random_step();
        logic       v;
        logic [7:0] d;
        v = ($urandom_range(0, 99) < 85);
        if (pos != 0 && $urandom_range(0, 9) < 8)
            d = msg[pos];
        else if ($urandom_range(0, 2) == 0)
            d = 8'h48;
        else
            d = 8'($urandom_range(0, 255));
        step(v, d);
        if ($urandom_range(0, 49) == 0)
            repeat ($urandom_range(2, 6)) step(1'b0, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;

        apply_reset();
        send_msg();
        step(1'b0, 8'h00);

        apply_reset();
        send_str("Help");
        step(1'b0, 8'h00);
        send_msg();

        apply_reset();
        send_str("HeH");
        send_str("ello, world!");
        step(1'b1, 8'h00);

        apply_reset();
        send_str("Hel");
        repeat (6) step(1'b0, 8'h00);
        send_str("xyzHel");
        repeat (3) step(1'b0, 8'h00);
        send_str("lo");

        apply_reset();
        send_str("Hello");
        apply_reset();
        repeat (3) step(1'b0, 8'h00);

        apply_reset();
        repeat (3000) random_step();

        apply_reset();
        repeat (257) send_msg();
        step(1'b0, 8'h00);

`ifdef MESSAGE_CHECK_ERRCNT_EN
        apply_reset();
        repeat (300) begin
            step(1'b1, 8'h48);
            step(1'b1, 8'h78);
        end
`endif

        repeat (2) step(1'b0, 8'h00);
        @(negedge clk);
        #1;
        chk("scoreboard drained", 16'(q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/message_check.md
MESSAGE_CHECK -- requirements
Module: message_check

Interface
REQ-001 Parameter TIMEOUT, default 1000: maximum idle cycles between bytes while in MATCH, range 0..65535; 0 disables the timeout.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_valid  input  1  byte strobe; one byte consumed per cycle in which it is high.
REQ-005 i_data  input  8  received byte, qualified by i_valid.
REQ-006 o_match  output  1  one-cycle pulse: complete expected message received.
REQ-007 o_error  output  1  one-cycle pulse: mismatch or timeout aborted a message in progress.
REQ-008 o_index  output  4  number of message bytes matched so far (0..13).
REQ-009 o_match_count  output  8  saturating count of completed messages.

Function
REQ-010 The expected message is 14 bytes, index 0..13: "H","e","l","l","o",","," ","w","o","r","l","d","!",0x00.
REQ-011 FSM states: HUNT (waiting for "H") and MATCH (mid-message); the block always accepts i_valid and has no backpressure.
REQ-012 In HUNT, a valid "H" moves to MATCH with o_index=1; any other valid byte is discarded silently, with no o_error.
REQ-013 In MATCH, a valid byte equal to expected[o_index] with o_index<13 increments o_index.
REQ-014 In MATCH, a valid 0x00 at o_index=13 pulses o_match the next cycle, increments o_match_count, and returns to HUNT with o_index=0.
REQ-015 In MATCH, a valid mismatching byte pulses o_error the next cycle.
REQ-016 After that mismatch, if the byte is "H" the FSM stays in MATCH with o_index=1; otherwise it goes to HUNT with o_index=0.
REQ-017 The idle counter clears on every valid byte and on entry to MATCH, and increments each MATCH cycle without i_valid.
REQ-018 With TIMEOUT>0, when the idle counter reaches TIMEOUT the block pulses o_error, goes to HUNT, and sets o_index=0.
REQ-019 Timeout is evaluated only on cycles with i_valid low; a valid byte on the expiry cycle is processed normally.
REQ-020 The idle counter is 16 bits and saturates; it is don't-care in HUNT.
REQ-021 o_match_count saturates at 255 and never wraps.
REQ-022 o_match and o_error are registered, last exactly one cycle, and are never asserted in the same cycle.
REQ-023 Latency: an o_match or o_error pulse appears on the cycle after the causing i_valid cycle.

Reset
REQ-024 Asserting i_reset immediately forces HUNT, o_index=0, o_match=0, o_error=0, o_match_count=0, idle counter=0, and the error counter when present.
REQ-025 Reset mid-message discards the partial match without an o_error pulse.
REQ-026 After i_reset deasserts, the first rising edge with i_valid high is processed normally.

Configuration
REQ-027 Macro MESSAGE_CHECK_ERRCNT_EN, when defined, adds output o_error_count (8 bits) that increments once per o_error pulse and saturates at 255.
REQ-028 Without MESSAGE_CHECK_ERRCNT_EN the o_error_count port and its logic are absent, and all other behaviour is identical.

Verification
REQ-029 Reset, then stream "Hello, world!",0x00 back-to-back -> one o_match pulse the cycle after the 0x00 byte; o_match_count=1; o_error never high.
REQ-030 Send "Help" -> o_error pulses after "p", then HUNT with o_index=0; send the full message -> o_match pulses and o_match_count=1.
REQ-031 Send "HeH" then "ello, world!",0x00 -> o_error pulses after the second "H", o_index=1, then o_match pulses.
REQ-032 With TIMEOUT=4, send "Hel" then idle -> o_error pulses after the 4th idle cycle and o_index=0.
REQ-033 Send 257 complete messages -> o_match_count holds 255; with MESSAGE_CHECK_ERRCNT_EN, 300 mismatches leave o_error_count=255.
REQ-034 Assert i_reset after "Hello" -> o_index=0 immediately, no o_error pulse, o_match_count=0.
